// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: owns the PC, drives the I-cache halfword address, fills IF/ID.
// Latency: an instruction lands in IF/ID one cycle after the cycle it is returned with ic_stall=0.
// Backpressure: hazard_stall holds PC and IF/ID; ic_stall holds PC and inserts bubbles. Optional FETCH_PERF_EN adds perf counters.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        proc_reset,
    output logic        ic_read,
    output logic [30:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_stall,
    input  logic        ic_pcadd,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_next,
    output logic        ifid_is_rvc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_rvc_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic {
        RUN,
        WAIT_REDIR
    } state_t;

    localparam logic [31:0] PC_RST = RESET_PC & ~32'h1;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_nxt;
    logic [31:0] redir_al;
    logic [31:0] pc_len;
    logic [31:0] pc_inc;
    logic        accept;
    logic        ifid_clr;

    assign ic_read  = ~proc_reset;
    assign ic_addr  = pc[31:1];
    assign redir_al = redirect_pc & ~32'h1;
    assign pc_len   = ic_pcadd ? 32'd4 : 32'd2;
    assign pc_inc   = pc + pc_len;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_pc_nxt = pend_pc;
        accept      = 1'b0;
        ifid_clr    = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    ifid_clr = 1'b1;
                    if (ic_stall) begin
                        // Address must stay stable under a miss; park the target.
                        pend_pc_nxt = redir_al;
                        state_nxt   = WAIT_REDIR;
                    end else begin
                        pc_nxt = redir_al;
                    end
                end else if (hazard_stall) begin
                    // hold everything
                end else if (ic_stall) begin
                    ifid_clr = 1'b1;
                end else begin
                    accept = 1'b1;
                    pc_nxt = pc_inc;
                end
            end
            WAIT_REDIR: begin
                ifid_clr = 1'b1;
                if (redirect_valid) begin
                    pend_pc_nxt = redir_al;
                end
                if (!ic_stall) begin
                    pc_nxt    = redirect_valid ? redir_al : pend_pc;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state        <= RUN;
            pc           <= PC_RST;
            pend_pc      <= 32'h0;
            ifid_valid   <= 1'b0;
            ifid_instr   <= 32'h0;
            ifid_pc      <= 32'h0;
            ifid_pc_next <= 32'h0;
            ifid_is_rvc  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_pc <= pend_pc_nxt;
            if (accept) begin
                ifid_valid   <= 1'b1;
                ifid_instr   <= ic_rdata;
                ifid_pc      <= pc;
                ifid_pc_next <= pc_inc;
                ifid_is_rvc  <= ~ic_pcadd;
            end else if (ifid_clr) begin
                ifid_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] rvc_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            fetch_cnt <= 32'h0;
            rvc_cnt   <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (accept) begin
                fetch_cnt <= fetch_cnt + 32'd1;
                if (!ic_pcadd) begin
                    rvc_cnt <= rvc_cnt + 32'd1;
                end
            end
            if (ic_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_rvc_cnt   = rvc_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_rvc_cnt   = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with RESET_PC=0x100; perf expectations follow FETCH_PERF_EN.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        proc_reset;
    logic        ic_read;
    logic [30:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_stall;
    logic        ic_pcadd;
    logic        hazard_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_next;
    logic        ifid_is_rvc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_rvc_cnt;
    logic [31:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .proc_reset     (proc_reset),
        .ic_read        (ic_read),
        .ic_addr        (ic_addr),
        .ic_rdata       (ic_rdata),
        .ic_stall       (ic_stall),
        .ic_pcadd       (ic_pcadd),
        .hazard_stall   (hazard_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_next   (ifid_pc_next),
        .ifid_is_rvc    (ifid_is_rvc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_rvc_cnt   (perf_rvc_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] pcn, input logic rvc);
        chk({tag, "_valid"}, {31'h0, ifid_valid}, {31'h0, v});
        if (v) begin
            chk({tag, "_instr"}, ifid_instr, instr);
            chk({tag, "_pc"}, ifid_pc, pc);
            chk({tag, "_pcnext"}, ifid_pc_next, pcn);
            chk({tag, "_rvc"}, {31'h0, ifid_is_rvc}, {31'h0, rvc});
        end
    endtask

    initial begin
        logic [31:0] exp_fetch;
        logic [31:0] exp_rvc;
        logic [31:0] exp_stall;
`ifdef FETCH_PERF_EN
        exp_fetch = 32'd10;
        exp_rvc   = 32'd4;
        exp_stall = 32'd10;
`else
        exp_fetch = 32'd0;
        exp_rvc   = 32'd0;
        exp_stall = 32'd0;
`endif
        proc_reset = 1'b1; ic_rdata = 32'h0; ic_stall = 1'b0; ic_pcadd = 1'b1;
        hazard_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();

        // Reset state
        chk("rst_ic_read", {31'h0, ic_read}, 32'h0);
        chk("rst_ic_addr", {1'b0, ic_addr}, 32'h80);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_ifid_instr", ifid_instr, 32'h0);
        chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);

        // Sequential fetch: 32/16/32
        proc_reset = 1'b0; ic_pcadd = 1'b1; ic_rdata = 32'hA000_0001;
        #1;
        chk("run_ic_read", {31'h0, ic_read}, 32'h1);
        step();
        chk_ifid("seq0", 1'b1, 32'hA000_0001, 32'h100, 32'h104, 1'b0);
        chk("seq0_addr", {1'b0, ic_addr}, 32'h82);
        ic_pcadd = 1'b0; ic_rdata = 32'hA000_0002;
        step();
        chk_ifid("seq1", 1'b1, 32'hA000_0002, 32'h104, 32'h106, 1'b1);
        chk("seq1_addr", {1'b0, ic_addr}, 32'h83);
        ic_pcadd = 1'b1; ic_rdata = 32'hA000_0003;
        step();
        chk_ifid("seq2", 1'b1, 32'hA000_0003, 32'h106, 32'h10A, 1'b0);
        chk("seq2_addr", {1'b0, ic_addr}, 32'h85);

        // I-cache miss at 0x200: three bubbles then accept
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        chk("redir200_valid", {31'h0, ifid_valid}, 32'h0);
        chk("redir200_addr", {1'b0, ic_addr}, 32'h100);
        redirect_valid = 1'b0; ic_stall = 1'b1; ic_rdata = 32'hBAD0_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("miss_addr", {1'b0, ic_addr}, 32'h100);
            chk("miss_bubble", {31'h0, ifid_valid}, 32'h0);
        end
        ic_stall = 1'b0; ic_pcadd = 1'b1; ic_rdata = 32'hB000_0001;
        step();
        chk_ifid("miss_acc", 1'b1, 32'hB000_0001, 32'h200, 32'h204, 1'b0);
        chk("miss_acc_addr", {1'b0, ic_addr}, 32'h102);

        // Redirect to 0x401 during a 4-cycle miss
        redirect_valid = 1'b1; redirect_pc = 32'h401; ic_stall = 1'b1; ic_rdata = 32'hDEAD_0001;
        step();
        chk("wr_addr0", {1'b0, ic_addr}, 32'h102);
        chk("wr_valid0", {31'h0, ifid_valid}, 32'h0);
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr_addr", {1'b0, ic_addr}, 32'h102);
            chk("wr_valid", {31'h0, ifid_valid}, 32'h0);
        end
        ic_stall = 1'b0; ic_rdata = 32'hDEAD_0002;
        step();
        chk("wr_exit_addr", {1'b0, ic_addr}, 32'h200);
        chk("wr_exit_discard", {31'h0, ifid_valid}, 32'h0);
        ic_pcadd = 1'b0; ic_rdata = 32'hC000_0001;
        step();
        chk_ifid("wr_acc", 1'b1, 32'hC000_0001, 32'h400, 32'h402, 1'b1);

        // Hazard stall with IF/ID at 0x300, with and without a miss
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0; ic_pcadd = 1'b1; ic_rdata = 32'hD000_0001;
        step();
        chk_ifid("hz_fill", 1'b1, 32'hD000_0001, 32'h300, 32'h304, 1'b0);
        hazard_stall = 1'b1; ic_stall = 1'b1; ic_rdata = 32'hBAD0_0001;
        step();
        chk_ifid("hz_miss", 1'b1, 32'hD000_0001, 32'h300, 32'h304, 1'b0);
        chk("hz_miss_addr", {1'b0, ic_addr}, 32'h182);
        ic_stall = 1'b0;
        step();
        chk_ifid("hz_hit", 1'b1, 32'hD000_0001, 32'h300, 32'h304, 1'b0);
        chk("hz_hit_addr", {1'b0, ic_addr}, 32'h182);
        hazard_stall = 1'b0; ic_pcadd = 1'b0; ic_rdata = 32'hD000_0002;
        step();
        chk_ifid("hz_rel", 1'b1, 32'hD000_0002, 32'h304, 32'h306, 1'b1);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        chk("wrap_top_addr", {1'b0, ic_addr}, 32'h7FFF_FFFF);
        redirect_valid = 1'b0; ic_pcadd = 1'b0; ic_rdata = 32'hE000_0001;
        step();
        chk_ifid("wrap2", 1'b1, 32'hE000_0001, 32'hFFFF_FFFE, 32'h0, 1'b1);
        chk("wrap2_addr", {1'b0, ic_addr}, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0; ic_pcadd = 1'b1; ic_rdata = 32'hE000_0002;
        step();
        chk_ifid("wrap4", 1'b1, 32'hE000_0002, 32'hFFFF_FFFC, 32'h0, 1'b0);
        chk("wrap4_addr", {1'b0, ic_addr}, 32'h0);
        ic_rdata = 32'hE000_0003;
        step();
        chk_ifid("post_wrap", 1'b1, 32'hE000_0003, 32'h0, 32'h4, 1'b0);

        // Pending redirect overwritten; hazard ignored on WAIT_REDIR exit
        redirect_valid = 1'b1; redirect_pc = 32'h500; ic_stall = 1'b1;
        step();
        redirect_pc = 32'h600;
        step();
        chk("ovr_addr", {1'b0, ic_addr}, 32'h2);
        redirect_valid = 1'b0; ic_stall = 1'b0; hazard_stall = 1'b1;
        step();
        chk("ovr_exit_addr", {1'b0, ic_addr}, 32'h300);
        chk("ovr_valid", {31'h0, ifid_valid}, 32'h0);
        hazard_stall = 1'b0;

        // Perf counters (all zero without FETCH_PERF_EN)
        chk("perf_fetch", perf_fetch_cnt, exp_fetch);
        chk("perf_rvc", perf_rvc_cnt, exp_rvc);
        chk("perf_stall", perf_stall_cnt, exp_stall);

        // Reset during WAIT_REDIR drops the pending redirect
        redirect_valid = 1'b1; redirect_pc = 32'h700; ic_stall = 1'b1;
        step();
        redirect_valid = 1'b0; proc_reset = 1'b1;
        step();
        proc_reset = 1'b0; ic_stall = 1'b0; ic_pcadd = 1'b1; ic_rdata = 32'hF000_0001;
        step();
        chk_ifid("rst_wait", 1'b1, 32'hF000_0001, 32'h100, 32'h104, 1'b0);
        chk("rst_wait_addr", {1'b0, ic_addr}, 32'h82);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
